// File: rtl/multicycle_processor.sv
// Multicycle processor: a single shared memory port serves both fetch and data,
// and an FSM sequences fetch/decode/execute/memory/writeback.
module multicycle_processor #(
  parameter int                DATA_W   = 32,
  parameter int                NREG     = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc,
  output logic              retire,
  output logic              halted
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LDR  = 4'd5;
  localparam logic [3:0] OP_STR  = 4'd6;
  localparam logic [3:0] OP_B    = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;
  localparam logic [3:0] OP_HLT  = 4'd15;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t            state, state_next;
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] a_val, b_val, d_val, res;
  logic [DATA_W-1:0] alu_res, simm, diff;
  logic [DATA_W:0]   sub_full;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic [3:0]        op;
  logic [RW-1:0]     rd_idx, rn_idx, rm_idx;
  logic              branch_taken;

  assign op       = ir[31:28];
  assign rd_idx   = ir[24 +: RW];
  assign rn_idx   = ir[20 +: RW];
  assign rm_idx   = ir[16 +: RW];
  assign simm     = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  // Subtraction as rn + ~rm + 1 so the top bit is the no-borrow carry
  assign sub_full = {1'b0, a_val} + {1'b0, ~b_val} + {{DATA_W{1'b0}}, 1'b1};
  assign diff     = sub_full[DATA_W-1:0];
  assign branch_taken = (op == OP_B) || ((op == OP_BEQ) && flag_z);
  assign halted   = (state == HALT);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_val + b_val;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = a_val & b_val;
      OP_ORR:  alu_res = a_val | b_val;
      default: alu_res = a_val + simm;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      FETCH:  if (mem_ready) state_next = DECODE;
      DECODE: state_next = EXEC;
      EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI: state_next = WB;
          OP_LDR, OP_STR: state_next = MEM;
          OP_HLT: begin
            state_next = HALT;
            retire     = 1'b1;
          end
          default: begin
            state_next = FETCH;
            retire     = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (op == OP_STR) begin
            state_next = FETCH;
            retire     = 1'b1;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Memory outputs are gated by rst so a reset abandons any transaction at once
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      case (state)
        FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        MEM: begin
          mem_req   = 1'b1;
          mem_we    = (op == OP_STR);
          mem_addr  = res;
          mem_wdata = d_val;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      a_val  <= '0;
      b_val  <= '0;
      d_val  <= '0;
      res    <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata[31:0];
            pc <= pc + PC_STEP;
          end
        end
        DECODE: begin
          a_val <= regs[rn_idx];
          b_val <= regs[rm_idx];
          d_val <= regs[rd_idx];
        end
        EXEC: begin
          res <= alu_res;
          if (op == OP_CMP) begin
            flag_n <= diff[DATA_W-1];
            flag_z <= (diff == '0);
            flag_c <= sub_full[DATA_W];
            flag_v <= (a_val[DATA_W-1] != b_val[DATA_W-1]) &&
                      (diff[DATA_W-1] != a_val[DATA_W-1]);
          end
          // pc already points past the branch, so the offset is relative to pc+4
          if (branch_taken) pc <= pc + (simm << 2);
        end
        MEM: begin
          if (mem_ready && (op == OP_LDR)) res <= mem_rdata;
        end
        WB: regs[rd_idx] <= res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed self-checking bench for multicycle_processor with a word memory model
// whose ready line can be held low for a chosen address.
module tb_multicycle_processor;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LDR  = 4'd5;
  localparam logic [3:0] OP_STR  = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;
  localparam logic [3:0] OP_HLT  = 4'd15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        mem_ready = 1'b1;

  logic [31:0] mem [0:255];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ret_cnt = 0;
  int          ret_cyc [8];
  int          wr_total = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] stall_addr = '0;
  int          stall_n = 0;
  int          stall_seen = 0;

  multicycle_processor #(.DATA_W(32), .NREG(16), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  // Ready is dropped for the first stall_n cycles of a request to stall_addr
  always @(negedge clk) begin
    if (stall_n > 0 && mem_req && mem_addr == stall_addr && stall_seen < stall_n) begin
      mem_ready = 1'b0;
      stall_seen++;
    end else begin
      mem_ready = 1'b1;
      if (!(mem_req && mem_addr == stall_addr)) stall_seen = 0;
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      cyc = 0;
      ret_cnt = 0;
    end else begin
      cyc++;
      if (retire) begin
        if (ret_cnt < 8) ret_cyc[ret_cnt] = cyc;
        ret_cnt++;
      end
      if (mem_req && mem_we && mem_ready) begin
        wr_total++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end
    end
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rn, input logic [3:0] rm,
                                      input logic [15:0] imm);
    return {op, rd, rn, rm, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic applyStimulus();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_halt(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (halted) break;
    end
    checkOutput(tag, {31'b0, halted}, 32'd1);
  endtask

  task automatic wait_retire(input int n, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (ret_cnt >= n) break;
    end
    checkOutput(tag, {31'b0, ret_cnt >= n}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wr_before, stall_obs, hold_bad, idle_bad;
    logic hs_seen, found;

    // Reset values, then program A: ADDI/ADDI/ADD/STR/HLT with zero-wait memory
    hold_reset();
    mem[64] = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd5);
    mem[65] = enc(OP_ADDI, 4'd2, 4'd0, 4'd0, 16'hFFFD);
    mem[66] = enc(OP_ADD,  4'd3, 4'd1, 4'd2, 16'd0);
    mem[67] = enc(OP_STR,  4'd3, 4'd0, 4'd0, 16'h0040);
    mem[68] = enc(OP_HLT,  4'd0, 4'd0, 4'd0, 16'd0);
    #1;
    checkOutput("rst_mem_req",   {31'b0, mem_req},   32'd0);
    checkOutput("rst_mem_we",    {31'b0, mem_we},    32'd0);
    checkOutput("rst_mem_addr",  mem_addr,           32'd0);
    checkOutput("rst_mem_wdata", mem_wdata,          32'd0);
    checkOutput("rst_retire",    {31'b0, retire},    32'd0);
    checkOutput("rst_halted",    {31'b0, halted},    32'd0);
    checkOutput("rst_pc",        pc,                 32'h100);
    wr_before = wr_total;
    applyStimulus();
    #1;
    checkOutput("first_fetch_req",  {31'b0, mem_req}, 32'd1);
    checkOutput("first_fetch_addr", mem_addr,         32'h100);
    wait_halt(80, "a_halted");
    checkOutput("a_ret_count",  ret_cnt, 32'd5);
    checkOutput("a_ret0_cyc",   ret_cyc[0], 32'd3);
    checkOutput("a_ret1_gap",   ret_cyc[1] - ret_cyc[0], 32'd4);
    checkOutput("a_ret2_gap",   ret_cyc[2] - ret_cyc[1], 32'd4);
    checkOutput("a_ret3_gap",   ret_cyc[3] - ret_cyc[2], 32'd4);
    checkOutput("a_hlt_gap",    ret_cyc[4] - ret_cyc[3], 32'd3);
    checkOutput("a_wr_count",   wr_total - wr_before, 32'd1);
    checkOutput("a_wr_addr",    wr_addr, 32'h40);
    checkOutput("a_wr_data",    wr_data, 32'd2);
    checkOutput("a_halt_pc",    pc, 32'h114);
    idle_bad = 0;
    repeat (22) begin
      @(negedge clk);
      #2;
      if (mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) idle_bad++;
    end
    checkOutput("halt_idle", idle_bad, 32'd0);
    checkOutput("halt_no_more_retire", ret_cnt, 32'd5);

    // CMP r1,r1 then BEQ -2 loops back to the CMP
    hold_reset();
    mem[64] = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd7);
    mem[65] = enc(OP_CMP,  4'd0, 4'd1, 4'd1, 16'd0);
    mem[66] = enc(OP_BEQ,  4'd0, 4'd0, 4'd0, 16'hFFFE);
    applyStimulus();
    wait_retire(3, 40, "beq_t_retired");
    checkOutput("beq_t_ret_cyc", ret_cyc[2], 32'd9);
    checkOutput("beq_t_pc_exec", pc, 32'h10C);
    @(negedge clk);
    #2;
    checkOutput("beq_t_pc_after", pc, 32'h104);

    // CMP of unequal values: BEQ falls through to HLT
    hold_reset();
    mem[64] = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd7);
    mem[65] = enc(OP_ADDI, 4'd2, 4'd0, 4'd0, 16'd8);
    mem[66] = enc(OP_CMP,  4'd0, 4'd1, 4'd2, 16'd0);
    mem[67] = enc(OP_BEQ,  4'd0, 4'd0, 4'd0, 16'hFFFE);
    mem[68] = enc(OP_HLT,  4'd0, 4'd0, 4'd0, 16'd0);
    applyStimulus();
    wait_halt(80, "beq_nt_halted");
    checkOutput("beq_nt_ret_count", ret_cnt, 32'd5);
    checkOutput("beq_nt_gap", ret_cyc[3] - ret_cyc[2], 32'd3);
    checkOutput("beq_nt_pc", pc, 32'h114);

    // LDR with three wait states, result stored back out
    hold_reset();
    mem[32] = 32'hDEADBEEF;
    mem[64] = enc(OP_LDR, 4'd4, 4'd0, 4'd0, 16'h0080);
    mem[65] = enc(OP_STR, 4'd4, 4'd0, 4'd0, 16'h0044);
    mem[66] = enc(OP_HLT, 4'd0, 4'd0, 4'd0, 16'd0);
    stall_addr = 32'h80;
    stall_n = 3;
    stall_obs = 0;
    hold_bad = 0;
    hs_seen = 1'b0;
    applyStimulus();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (!mem_ready) begin
        stall_obs++;
        if (mem_addr !== 32'h80 || mem_req !== 1'b1 || mem_we !== 1'b0) hold_bad++;
      end else if (stall_obs > 0 && !hs_seen) begin
        hs_seen = 1'b1;
        checkOutput("ldr_hs_addr", mem_addr, 32'h80);
        checkOutput("ldr_hs_req",  {31'b0, mem_req}, 32'd1);
      end
      if (halted) break;
    end
    checkOutput("ldr_halted",    {31'b0, halted}, 32'd1);
    checkOutput("ldr_stalls",    stall_obs, 32'd3);
    checkOutput("ldr_hold",      hold_bad, 32'd0);
    checkOutput("ldr_hs_seen",   {31'b0, hs_seen}, 32'd1);
    checkOutput("ldr_latency",   ret_cyc[0], 32'd7);
    checkOutput("ldr_data",      wr_data, 32'hDEADBEEF);
    checkOutput("ldr_st_addr",   wr_addr, 32'h44);
    stall_n = 0;

    // CMP 0x80000000 - 1 overflows into a positive result
    hold_reset();
    mem[18] = 32'h80000000;
    mem[64] = enc(OP_LDR,  4'd1, 4'd0, 4'd0, 16'h0048);
    mem[65] = enc(OP_ADDI, 4'd2, 4'd0, 4'd0, 16'd1);
    mem[66] = enc(OP_CMP,  4'd0, 4'd1, 4'd2, 16'd0);
    mem[67] = enc(OP_HLT,  4'd0, 4'd0, 4'd0, 16'd0);
    applyStimulus();
    wait_halt(80, "cmp_v_halted");
    checkOutput("cmp_v_flag", {31'b0, dut.flag_v}, 32'd1);
    checkOutput("cmp_n_flag", {31'b0, dut.flag_n}, 32'd0);
    checkOutput("cmp_z_flag", {31'b0, dut.flag_z}, 32'd0);
    checkOutput("cmp_c_flag", {31'b0, dut.flag_c}, 32'd1);

    // Reset while a STR sits stalled in MEM
    hold_reset();
    mem[64] = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd9);
    mem[65] = enc(OP_STR,  4'd1, 4'd0, 4'd0, 16'h0050);
    mem[66] = enc(OP_HLT,  4'd0, 4'd0, 4'd0, 16'd0);
    stall_addr = 32'h50;
    stall_n = 50;
    found = 1'b0;
    applyStimulus();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (!mem_ready && mem_we) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort_stall_seen", {31'b0, found}, 32'd1);
    wr_before = wr_total;
    rst = 1'b0;
    #1;
    checkOutput("abort_req",  {31'b0, mem_req}, 32'd0);
    checkOutput("abort_we",   {31'b0, mem_we},  32'd0);
    checkOutput("abort_addr", mem_addr, 32'd0);
    checkOutput("abort_pc",   pc, 32'h100);
    stall_n = 0;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("abort_no_write", wr_total - wr_before, 32'd0);
    applyStimulus();
    wait_halt(60, "abort_rerun_halted");
    checkOutput("abort_rerun_write", wr_total - wr_before, 32'd1);
    checkOutput("abort_rerun_data",  wr_data, 32'd9);
    checkOutput("abort_rerun_pc",    pc, 32'h10C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_processor.md
# multicycle_processor

Parametrised multicycle successor to the single-cycle processor top. One shared memory port carries both instruction fetch and data access, with a req/ready handshake that tolerates wait states. Fetch, decode, execute, memory and writeback are sequenced by an internal FSM. The block sits between the system memory/bus fabric and the rest of the SoC, and exposes retire/halt status for debug and verification.

## Interface
- DATA_W, 32: register, ALU and address width; must be ≥32.
- NREG, 16: register count, a power of 2, ≤16; register fields use their low log2(NREG) bits.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: asynchronous, active-low reset.
- mem_req  out  1: memory transaction request.
- mem_we  out  1: 1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  DATA_W: byte address.
- mem_wdata  out  DATA_W: store data.
- mem_rdata  in  DATA_W: read data; valid in the cycle mem_ready is high. Instructions are taken from mem_rdata[31:0].
- mem_ready  in  1: transaction completes at a clock edge where mem_req and mem_ready are both high.
- pc  out  DATA_W: address of the current/next instruction.
- retire  out  1: one-cycle pulse in the final state of each instruction.
- halted  out  1: high once HLT has executed.

## Operation
- Instruction fields:
  - [31:28] op
  - [27:24] rd
  - [23:20] rn
  - [19:16] rm
  - [15:0] imm, sign-extended to DATA_W as simm.
- Opcodes:
  - 0 ADD: rd = rn + rm.
  - 1 SUB: rd = rn − rm.
  - 2 AND: rd = rn & rm.
  - 3 ORR: rd = rn | rm.
  - 4 ADDI: rd = rn + simm.
  - 5 LDR: rd = mem[rn + simm].
  - 6 STR: mem[rn + simm] = rd.
  - 7 B: pc = pc + (simm << 2).
  - 8 BEQ: as B, taken only if Z = 1.
  - 9 CMP: flags from rn − rm; no register write.
  - 15 HLT: halt.
  - Any other opcode: NOP.
- Flags N, Z, C, V are updated only by CMP.
  - C = no borrow, i.e. carry-out of rn + ~rm + 1.
  - V = signed overflow.
- Arithmetic is modulo 2^DATA_W. Addresses are not alignment-checked.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req = 1, mem_we = 0, mem_addr = pc.
  - On handshake: latch IR, pc ← pc + 4, go to DECODE.
- DECODE: read rn, rm, and rd (rd is the store source); go to EXEC.
- EXEC:
  - Compute ALU result, address or branch target.
  - ALU ops and ADDI go to WB.
  - LDR and STR go to MEM.
  - B, BEQ, CMP and NOP finish here (retire = 1) and return to FETCH. A branch updates pc at this edge.
  - HLT goes to HALT with retire = 1.
- MEM:
  - mem_req = 1, mem_addr = the address computed in EXEC, mem_we = (op == STR), mem_wdata = rd value.
  - Stays in MEM until the handshake completes.
  - LDR latches mem_rdata and goes to WB.
  - STR asserts retire in its handshake cycle and goes to FETCH.
- WB: write rd, retire = 1, go to FETCH.
- HALT: terminal state. mem_req = 0 and halted = 1 until reset.
- Register file: NREG × DATA_W, all writable, cleared on reset. Written only in WB.

## Timing
- Asynchronous reset, while rst = 0:
  - State = FETCH, pc = RESET_PC, registers and flags = 0.
  - mem_req = 0, mem_we = 0, retire = 0, halted = 0.
  - mem_addr and mem_wdata = 0.
- Mid-transaction reset: mem_req drops combinationally and the transaction is abandoned. The first FETCH starts on the first rising edge after rst rises.
- Handshake rules:
  - While mem_req is high, mem_addr, mem_we and mem_wdata are held stable until completion.
  - mem_req may fall in the cycle after completion.
  - mem_ready while mem_req = 0 is ignored.
- Latency with mem_ready tied high (cycles per instruction):
  - ALU/ADDI: 4 (FETCH, DECODE, EXEC, WB).
  - LDR: 5.
  - STR: 4.
  - B/BEQ/CMP/NOP/HLT: 3.
  - Each memory wait cycle adds 1 cycle.
- pc changes only at fetch completion (+4) or at EXEC of a taken branch. The output pc is the register value.
- Register-after-write: the value written in WB is visible to the next instruction's DECODE (no forwarding needed).
- A branch wrapping past 2^DATA_W wraps modulo 2^DATA_W.

## Test plan
- Reset with RESET_PC = 0x100:
  - First mem_addr = 0x100 with mem_req = 1.
  - All outputs are at their reset values while rst = 0.
- Program ADDI r1,r0,5; ADDI r2,r0,−3; ADD r3,r1,r2; STR r3,[r0+0x40] with zero-wait memory:
  - Write at 0x40 with data 2.
  - Exactly 4 retire pulses, spaced 4 cycles apart.
- CMP r1,r1 followed by BEQ imm = −2:
  - Branch taken; pc returns to the CMP address.
  - With r1 ≠ r2, the branch is not taken and pc advances by 4.
- LDR with mem_ready held low for 3 cycles in MEM:
  - mem_addr and mem_req stay stable throughout.
  - The instruction completes in 8 cycles; rd = the returned data.
- rst asserted mid-MEM of a STR:
  - mem_req falls immediately and no write completes.
  - pc = RESET_PC afterwards.
- HLT:
  - retire pulses once, then halted = 1 and mem_req stays 0 for 20 or more cycles.
  - CMP of 0x80000000 − 1 sets V = 1 and N = 0.
